// File: rtl/bitor20_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit bitwise-OR unit between two requesters.
// Optional macro BITOR_ARB_STATS_EN adds saturating per-requester grant counters cnt0/cnt1.
module bitor20_arbiter #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ack,
  output logic             busy
`ifdef BITOR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             win_q, win_d;
  logic             last_q, last_d;
  logic             win_s;

  // On a tie the requester that did not win last time is chosen
  assign win_s = req1 & (~req0 | ~last_q);

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    win_d       = win_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          win_d   = win_s;
          opa_d   = win_s ? a1 : a0;
          opb_d   = win_s ? b1 : b0;
          gnt0_d  = ~win_s;
          gnt1_d  = win_s;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d  = opa_q | opb_q;
        rsp_id_d    = win_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ack) begin
          rsp_valid_d = 1'b0;
          last_d      = win_q;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
      opa_q       <= {WIDTH{1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      win_q       <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      win_q       <= win_d;
      last_q      <= last_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

`ifdef BITOR_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Saturating grant counters, bumped on the edge that raises the grant
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0_d && (cnt0_q != CNT_MAX)) begin
      cnt0_d = cnt0_q + CNT_ONE;
    end else begin
      cnt0_d = cnt0_q;
    end
    if (gnt1_d && (cnt1_q != CNT_MAX)) begin
      cnt1_d = cnt1_q + CNT_ONE;
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= {CNT_W{1'b0}};
      cnt1_q <= {CNT_W{1'b0}};
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
